// File: rtl/lrf_frame_sequencer_if.sv
// AXI-Stream style bundle used for the two frame inputs and the core-facing output.
interface lrf_frame_sequencer_if #(
  parameter int DATA_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/lrf_frame_sequencer.sv
// Frame pair sequencer: forwards one full reference frame, then one full new frame,
// for a programmed number of pairs into a 2-entry output FIFO feeding the fusion core.
module lrf_frame_sequencer #(
  parameter int DATA_WIDTH      = 128,
  parameter int WORDS_PER_FRAME = 16384,
  parameter int PAIR_W          = 16
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_areset,
  input  logic                   cfg_start,
  input  logic [PAIR_W-1:0]      cfg_num_pairs,
  lrf_frame_sequencer_if.slave   s_old,
  lrf_frame_sequencer_if.slave   s_new,
  lrf_frame_sequencer_if.master  m_axis,
  output logic                   busy,
  output logic                   done,
  output logic [PAIR_W-1:0]      pair_idx
);

  localparam int BEAT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OLD   = 3'd1,
    NEW   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t              state_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic [PAIR_W-1:0]   num_pairs_reg;
  logic [PAIR_W-1:0]   pair_idx_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [1:0]          fifo_cnt_reg;
  logic                wr_ptr_reg;
  logic                rd_ptr_reg;

  logic                fifo_full;
  logic                old_acc;
  logic                new_acc;
  logic                push;
  logic                pop;
  logic                frame_end;
  logic                last_pair;
  logic [DATA_WIDTH-1:0] push_data;
  logic                push_user;
  logic                push_last;

  // Only the active phase's stream sees ready; the full check ignores a same-cycle
  // pop so ready depends on registers alone.
  assign fifo_full    = (fifo_cnt_reg == 2'd2);
  assign s_old.tready = (state_reg == OLD) && !fifo_full;
  assign s_new.tready = (state_reg == NEW) && !fifo_full;
  assign old_acc      = s_old.tready && s_old.tvalid;
  assign new_acc      = s_new.tready && s_new.tvalid;
  assign push         = old_acc || new_acc;
  assign pop          = (fifo_cnt_reg != 2'd0) && m_axis.tready;
  assign frame_end    = (beat_cnt_reg == LAST_BEAT);
  assign last_pair    = (pair_idx_reg == (num_pairs_reg - 1'b1));

  assign push_data = (state_reg == NEW) ? s_new.tdata : s_old.tdata;
  assign push_user = (state_reg == NEW);
  assign push_last = new_acc && frame_end && last_pair;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign pair_idx = pair_idx_reg;

  // Sequencing FSM: phase selection, beat/pair counting and status outputs.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_reg     <= IDLE;
      beat_cnt_reg  <= '0;
      num_pairs_reg <= '0;
      pair_idx_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            num_pairs_reg <= cfg_num_pairs;
            busy_reg      <= 1'b1;
            beat_cnt_reg  <= '0;
            pair_idx_reg  <= '0;
            state_reg     <= (cfg_num_pairs == '0) ? FIN : OLD;
          end
        end
        OLD: begin
          if (old_acc) begin
            if (frame_end) begin
              beat_cnt_reg <= '0;
              state_reg    <= NEW;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        NEW: begin
          if (new_acc) begin
            if (frame_end) begin
              beat_cnt_reg <= '0;
              if (last_pair) begin
                state_reg <= DRAIN;
              end else begin
                pair_idx_reg <= pair_idx_reg + 1'b1;
                state_reg    <= OLD;
              end
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fifo_cnt_reg == 2'd0) begin
            state_reg <= FIN;
          end
        end
        FIN: begin
          // busy falls in the same cycle the done pulse appears.
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // FIFO occupancy and pointers; simultaneous push and pop keep the count.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      fifo_cnt_reg <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  user_reg;
      logic                  last_reg;

      // One FIFO slot; cleared on reset so the idle output bus reads zero.
      always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
          data_reg <= '0;
          user_reg <= 1'b0;
          last_reg <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= push_data;
          user_reg <= push_user;
          last_reg <= push_last;
        end
      end
    end
  endgenerate

  // Head of the FIFO drives the core; it only moves on a pop, so it holds under backpressure.
  assign m_axis.tvalid = (fifo_cnt_reg != 2'd0);
  assign m_axis.tdata  = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
  assign m_axis.tuser  = rd_ptr_reg ? g_entry[1].user_reg : g_entry[0].user_reg;
  assign m_axis.tlast  = rd_ptr_reg ? g_entry[1].last_reg : g_entry[0].last_reg;

endmodule
